// File: rtl/demux_1to4_6bits_reg.sv
// -----------------------------------------------------------------------------
// demux_1to4_6bits_reg
//
// Registered 1-to-4 distributor for WIDTH-bit words. One input word is steered
// by in_sel into one of four holding registers. Each holding register has its
// own valid/ready handshake toward its consumer. A saturating counter per
// output counts the words that output has delivered.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous reset, active-low
//   in_valid     in   1      in_sel / in_data are valid
//   in_ready     out  1      input word is accepted this cycle
//   in_sel       in   2      destination index 0..3
//   in_data      in   WIDTH  word to deliver
//   out_valid    out  4      bit i: holding register i has an undelivered word
//   out_ready    in   4      bit i: consumer i takes out_data<i> this cycle
//   out_data0..3 out  WIDTH  holding registers
//   out_cnt0..3  out  CNT_W  saturating per-output delivery counters
// -----------------------------------------------------------------------------
module demux_1to4_6bits_reg #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [CNT_W-1:0] out_cnt0,
  output logic [CNT_W-1:0] out_cnt1,
  output logic [CNT_W-1:0] out_cnt2,
  output logic [CNT_W-1:0] out_cnt3
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       r_valid;
  logic [WIDTH-1:0] r_data [4];
  logic [CNT_W-1:0] r_cnt  [4];

  logic             w_in_ready;
  logic             w_accept;
  logic [3:0]       w_take;
  logic [3:0]       w_load;

  // Ready looks only at the selected register: it is free if empty, or if its
  // consumer drains it this same cycle (full throughput, no bubble).
  assign w_in_ready = ~r_valid[in_sel] | out_ready[in_sel];
  assign w_accept   = in_valid & w_in_ready;
  assign w_take     = r_valid & out_ready;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_load = 4'b0000;
    if (w_accept) begin
      w_load[in_sel] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 4'b0000;
      // NOTE: the holding registers are reset too because their outputs are
      // visible and must read zero during reset; a pure storage array would
      // normally be left unreset.
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        // A load wins over a take: a simultaneous drain-and-refill keeps
        // the register valid with the new word.
        if (w_load[i]) begin
          r_data[i]  <= in_data;
          r_valid[i] <= 1'b1;
        end else if (w_take[i]) begin
          r_valid[i] <= 1'b0;
        end

        if (w_take[i] && (r_cnt[i] != CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];
  assign out_cnt0  = r_cnt[0];
  assign out_cnt1  = r_cnt[1];
  assign out_cnt2  = r_cnt[2];
  assign out_cnt3  = r_cnt[3];

endmodule

// File: tb/tb_demux_1to4_6bits_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1to4_6bits_reg
//
// Directed bench for demux_1to4_6bits_reg. A table of single-cycle vectors
// covers steering, backpressure, stalls and concurrent drain; hand-written
// sequences cover asynchronous reset, back-to-back throughput and counter
// saturation (on a second instance with CNT_W=3).
// -----------------------------------------------------------------------------
module tb_demux_1to4_6bits_reg;

  localparam int WIDTH = 6;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;

  // Main instance (CNT_W = 8)
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [CNT_W-1:0] out_cnt0, out_cnt1, out_cnt2, out_cnt3;

  // Saturation instance (CNT_W = 3)
  logic             q_in_valid;
  logic             q_in_ready;
  logic [1:0]       q_in_sel;
  logic [WIDTH-1:0] q_in_data;
  logic [3:0]       q_out_valid;
  logic [3:0]       q_out_ready;
  logic [WIDTH-1:0] q_out_data0, q_out_data1, q_out_data2, q_out_data3;
  logic [2:0]       q_out_cnt0, q_out_cnt1, q_out_cnt2, q_out_cnt3;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  demux_1to4_6bits_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_cnt0(out_cnt0), .out_cnt1(out_cnt1), .out_cnt2(out_cnt2), .out_cnt3(out_cnt3)
  );

  demux_1to4_6bits_reg #(.WIDTH(WIDTH), .CNT_W(3)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .in_valid(q_in_valid), .in_ready(q_in_ready), .in_sel(q_in_sel), .in_data(q_in_data),
    .out_valid(q_out_valid), .out_ready(q_out_ready),
    .out_data0(q_out_data0), .out_data1(q_out_data1), .out_data2(q_out_data2), .out_data3(q_out_data3),
    .out_cnt0(q_out_cnt0), .out_cnt1(q_out_cnt1), .out_cnt2(q_out_cnt2), .out_cnt3(q_out_cnt3)
  );

  typedef struct packed {
    logic             vld;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
    logic [3:0]       rdy;
    logic             exp_in_ready;   // combinational, before the edge
    logic [3:0]       exp_valid;      // after the edge
    logic [3:0][WIDTH-1:0] exp_data;
    logic [3:0][CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic vld, input logic [1:0] sel,
                              input logic [5:0] data, input logic [3:0] rdy,
                              input logic er, input logic [3:0] ev,
                              input logic [5:0] d0, input logic [5:0] d1,
                              input logic [5:0] d2, input logic [5:0] d3,
                              input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
    vec_t v;
    v.vld = vld; v.sel = sel; v.data = data; v.rdy = rdy;
    v.exp_in_ready = er; v.exp_valid = ev;
    v.exp_data = {d3, d2, d1, d0};
    v.exp_cnt  = {c3, c2, c1, c0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] ev,
                             input logic [3:0][WIDTH-1:0] ed,
                             input logic [3:0][CNT_W-1:0] ec);
    check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, " out_data0"}, 32'(out_data0), 32'(ed[0]));
    check({tag, " out_data1"}, 32'(out_data1), 32'(ed[1]));
    check({tag, " out_data2"}, 32'(out_data2), 32'(ed[2]));
    check({tag, " out_data3"}, 32'(out_data3), 32'(ed[3]));
    check({tag, " out_cnt0"},  32'(out_cnt0),  32'(ec[0]));
    check({tag, " out_cnt1"},  32'(out_cnt1),  32'(ec[1]));
    check({tag, " out_cnt2"},  32'(out_cnt2),  32'(ec[2]));
    check({tag, " out_cnt3"},  32'(out_cnt3),  32'(ec[3]));
  endtask

  task automatic drive(input logic vld, input logic [1:0] sel,
                       input logic [5:0] data, input logic [3:0] rdy);
    in_valid  = vld;
    in_sel    = sel;
    in_data   = data;
    out_ready = rdy;
  endtask

  // Watchdog: the stimulus is a fixed number of cycles, so this only fires
  // if the bench itself stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            vld sel data   rdy     rdy? valid    d0     d1     d2     d3     c0 c1 c2 c3
    // T2 steer
    vecs[0] = mk(1, 2, 6'h2A, 4'b0000, 1, 4'b0100, 6'h00, 6'h00, 6'h2A, 6'h00, 0, 0, 0, 0);
    // T3 backpressure on sel=2, then the same word to free sel=1
    vecs[1] = mk(1, 2, 6'h15, 4'b0000, 0, 4'b0100, 6'h00, 6'h00, 6'h2A, 6'h00, 0, 0, 0, 0);
    vecs[2] = mk(1, 1, 6'h15, 4'b0000, 1, 4'b0110, 6'h00, 6'h15, 6'h2A, 6'h00, 0, 0, 0, 0);
    // Fill the remaining registers
    vecs[3] = mk(1, 0, 6'h07, 4'b0000, 1, 4'b0111, 6'h07, 6'h15, 6'h2A, 6'h00, 0, 0, 0, 0);
    vecs[4] = mk(1, 3, 6'h3F, 4'b0000, 1, 4'b1111, 6'h07, 6'h15, 6'h2A, 6'h3F, 0, 0, 0, 0);
    // T5 concurrent drain of all four with a refill of output 0
    vecs[5] = mk(1, 0, 6'h22, 4'b1111, 1, 4'b0001, 6'h22, 6'h15, 6'h2A, 6'h3F, 1, 1, 1, 1);
    // out_ready on an empty register is not a take
    vecs[6] = mk(0, 0, 6'h11, 4'b0010, 0, 4'b0001, 6'h22, 6'h15, 6'h2A, 6'h3F, 1, 1, 1, 1);
    // Stall: valid word for a full, undrained register must not overwrite it
    vecs[7] = mk(1, 0, 6'h33, 4'b0000, 0, 4'b0001, 6'h22, 6'h15, 6'h2A, 6'h3F, 1, 1, 1, 1);
    // Take on 0 with no input: valid drops, data holds
    vecs[8] = mk(0, 1, 6'h05, 4'b0001, 1, 4'b0000, 6'h22, 6'h15, 6'h2A, 6'h3F, 2, 1, 1, 1);
    // Accept to 1 while its (empty) consumer is ready
    vecs[9] = mk(1, 1, 6'h0C, 4'b0010, 1, 4'b0010, 6'h22, 6'h0C, 6'h2A, 6'h3F, 2, 1, 1, 1);

    drive(0, 0, 6'h00, 4'b0000);
    q_in_valid = 1'b0; q_in_sel = 2'd0; q_in_data = '0; q_out_ready = 4'b0000;
    reset_n = 1'b0;

    // Reset state
    #3;
    check_state("reset", 4'b0000, '0, '0);
    check("reset sat out_cnt1", 32'(q_out_cnt1), 32'd0);

    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors: drive at negedge, check in_ready before the
    // edge, check registered state at the following negedge.
    for (int k = 0; k < 10; k++) begin
      drive(vecs[k].vld, vecs[k].sel, vecs[k].data, vecs[k].rdy);
      #1;
      check($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'(vecs[k].exp_in_ready));
      @(negedge clk);
      check_state($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_data, vecs[k].exp_cnt);
    end

    // T1: asynchronous reset mid-traffic with out_valid = 4'b1011
    drive(1, 0, 6'h01, 4'b0000);
    @(negedge clk);
    drive(1, 3, 6'h02, 4'b0000);
    @(negedge clk);
    check("T1 pre-reset out_valid", 32'(out_valid), 32'b1011);
    drive(0, 0, 6'h00, 4'b0000);
    #2;
    reset_n = 1'b0;
    #1;  // well before the next rising edge: reset must act immediately
    check_state("T1 async", 4'b0000, '0, '0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("T1 in_ready sel=%0d", s), 32'(in_ready), 32'd1);
    end

    // T4: back-to-back words into output 3 with its consumer always ready
    @(negedge clk);
    for (int w = 1; w <= 16; w++) begin
      drive(1, 3, 6'(w), 4'b1000);
      #1;
      check($sformatf("T4 in_ready w=%0d", w), 32'(in_ready), 32'd1);
      @(negedge clk);
      check($sformatf("T4 out_data3 w=%0d", w), 32'(out_data3), 32'(w));
      check($sformatf("T4 out_valid w=%0d", w), 32'(out_valid), 32'b1000);
    end
    drive(0, 3, 6'h00, 4'b1000);
    @(negedge clk);
    check("T4 drained out_valid", 32'(out_valid), 32'b0000);
    check("T4 out_cnt3", 32'(out_cnt3), 32'd16);
    check("T4 out_cnt0", 32'(out_cnt0), 32'd0);

    // T6: saturation on the CNT_W=3 instance, output 1. Each cycle both
    // accepts and (after the first) takes, so after cycle i there were i takes.
    drive(0, 0, 6'h00, 4'b0000);
    for (int i = 0; i <= 10; i++) begin
      q_in_valid  = 1'b1;
      q_in_sel    = 2'd1;
      q_in_data   = 6'(i + 1);
      q_out_ready = 4'b0010;
      @(negedge clk);
      check($sformatf("T6 out_cnt1 after %0d takes", i), 32'(q_out_cnt1), 32'((i < 7) ? i : 7));
    end
    q_in_valid  = 1'b0;
    q_out_ready = 4'b0000;
    check("T6 out_cnt0 untouched", 32'(q_out_cnt0), 32'd0);
    check("T6 last word", 32'(q_out_data1), 32'h0B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
